// File: rtl/fmdll_lock_ctrl.sv
// fmdll_lock_ctrl -- lock controller for the frequency-multiplying DLL.
//
// Sequences the ring-mode select over each reference window:
// GATE (GATE_CYC cycles), INJECT (1 cycle), then RUN (max(M,1) cycles).
// The RUN -> INJECT loop repeats. On the last RUN cycle of a window, a valid
// phase-detector sample updates the DCDL code. The first CODE_W updates form
// a successive-approximation search. After that, the code moves by +/-1
// (tracking), with lock and unlock detection. Any change on N or M restarts
// the whole acquisition.
//
// Ports:
//   clk_ext   reference clock; the only clock
//   rst_n     synchronous active-low reset
//   N         multiplication factor (only watched for changes)
//   M         recirculation cycles per window; 0 behaves as 1
//   pd_lead   1 = output edge leads the reference (delay too short)
//   pd_valid  pd_lead is meaningful this cycle
//   code      DCDL delay code
//   Sel       00 recirculate, 01 inject clk_ext, 10 gate
//   lock      loop locked
//   eval      pulses in the cycle whose clock edge applies a code update
//   sat       tracking code sits at 0 or all-ones
module fmdll_lock_ctrl #(
    parameter int CODE_W     = 10,
    parameter int N_W        = 4,
    parameter int M_W        = 2,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_ERR = 4,
    parameter int GATE_CYC   = 2
) (
    input  logic              clk_ext,
    input  logic              rst_n,
    input  logic [N_W-1:0]    N,
    input  logic [M_W-1:0]    M,
    input  logic              pd_lead,
    input  logic              pd_valid,
    output logic [CODE_W-1:0] code,
    output logic [1:0]        Sel,
    output logic              lock,
    output logic              eval,
    output logic              sat
);

    localparam int CNT_MAX = (GATE_CYC > (1 << M_W)) ? GATE_CYC : (1 << M_W);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIT_W   = $clog2(LOCK_CNT + 1);
    localparam int SAME_W  = $clog2(UNLOCK_ERR + 1);
    localparam int BIT_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [CODE_W-1:0] MIDSCALE = CODE_W'(1) << (CODE_W - 1);

    // The state encoding is the Sel value itself. Sel is therefore a plain
    // register output, and it changes only when the state changes.
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_INJECT = 2'b01,
        ST_GATE   = 2'b10
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [N_W-1:0]     n_sh_reg, n_sh_next;
    logic [M_W-1:0]     m_sh_reg, m_sh_next;
    logic [CODE_W-1:0]  code_reg, code_next;
    logic [BIT_W-1:0]   bit_reg, bit_next;
    logic               track_reg, track_next;
    logic               lock_reg, lock_next;
    logic [DIT_W-1:0]   dither_reg, dither_next;
    logic [SAME_W-1:0]  same_reg, same_next;
    logic               prev_dir_reg, prev_dir_next;
    logic               prev_ok_reg, prev_ok_next;

    logic [M_W-1:0]     m_eff;
    logic               run_last;
    logic               changed;
    logic               do_eval;

    assign m_eff    = (m_sh_reg == '0) ? M_W'(1) : m_sh_reg;
    assign run_last = (cnt_reg == CNT_W'(m_eff - M_W'(1)));
    assign changed  = (N != n_sh_reg) || (M != m_sh_reg);
    // A pending N/M change suppresses the update, even on the last RUN cycle.
    assign do_eval  = rst_n && !changed && (state_reg == ST_RUN) && run_last && pd_valid;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        n_sh_next     = n_sh_reg;
        m_sh_next     = m_sh_reg;
        code_next     = code_reg;
        bit_next      = bit_reg;
        track_next    = track_reg;
        lock_next     = lock_reg;
        dither_next   = dither_reg;
        same_next     = same_reg;
        prev_dir_next = prev_dir_reg;
        prev_ok_next  = prev_ok_reg;

        case (state_reg)
            ST_GATE: begin
                if (cnt_reg == CNT_W'(GATE_CYC - 1)) begin
                    state_next = ST_INJECT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_INJECT: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
            ST_RUN: begin
                if (run_last) begin
                    state_next = ST_INJECT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_GATE;
                cnt_next   = '0;
            end
        endcase

        if (do_eval) begin
            if (!track_reg) begin
                // SAR step: decide bit b, then make bit b-1 the next trial bit.
                if (!pd_lead) begin
                    code_next[bit_reg] = 1'b0;
                end
                if (bit_reg != '0) begin
                    code_next[bit_reg - BIT_W'(1)] = 1'b1;
                    bit_next = bit_reg - BIT_W'(1);
                end else begin
                    track_next   = 1'b1;
                    prev_ok_next = 1'b0;
                    prev_dir_next = 1'b0;
                    dither_next  = '0;
                    same_next    = '0;
                end
            end else begin
                // Saturating +/-1. A saturated step still counts as a direction.
                if (pd_lead) begin
                    if (code_reg != '1) begin
                        code_next = code_reg + CODE_W'(1);
                    end
                end else begin
                    if (code_reg != '0) begin
                        code_next = code_reg - CODE_W'(1);
                    end
                end

                if (!prev_ok_reg) begin
                    dither_next = DIT_W'(1);
                    same_next   = '0;
                end else if (pd_lead != prev_dir_reg) begin
                    if (dither_reg != DIT_W'(LOCK_CNT)) begin
                        dither_next = dither_reg + DIT_W'(1);
                    end
                    same_next = '0;
                end else begin
                    dither_next = '0;
                    if (same_reg != SAME_W'(UNLOCK_ERR)) begin
                        same_next = same_reg + SAME_W'(1);
                    end
                end
                prev_dir_next = pd_lead;
                prev_ok_next  = 1'b1;

                // Unlock has priority. Dropping lock also restarts the
                // dither count.
                if (lock_reg && (same_next == SAME_W'(UNLOCK_ERR))) begin
                    lock_next   = 1'b0;
                    dither_next = '0;
                end else if (dither_next == DIT_W'(LOCK_CNT)) begin
                    lock_next = 1'b1;
                end
            end
        end

        if (changed) begin
            state_next    = ST_GATE;
            cnt_next      = '0;
            n_sh_next     = N;
            m_sh_next     = M;
            code_next     = MIDSCALE;
            bit_next      = BIT_W'(CODE_W - 1);
            track_next    = 1'b0;
            lock_next     = 1'b0;
            dither_next   = '0;
            same_next     = '0;
            prev_dir_next = 1'b0;
            prev_ok_next  = 1'b0;
        end
    end

    always_ff @(posedge clk_ext) begin
        if (!rst_n) begin
            state_reg    <= ST_GATE;
            cnt_reg      <= '0;
            n_sh_reg     <= N;
            m_sh_reg     <= M;
            code_reg     <= MIDSCALE;
            bit_reg      <= BIT_W'(CODE_W - 1);
            track_reg    <= 1'b0;
            lock_reg     <= 1'b0;
            dither_reg   <= '0;
            same_reg     <= '0;
            prev_dir_reg <= 1'b0;
            prev_ok_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            n_sh_reg     <= n_sh_next;
            m_sh_reg     <= m_sh_next;
            code_reg     <= code_next;
            bit_reg      <= bit_next;
            track_reg    <= track_next;
            lock_reg     <= lock_next;
            dither_reg   <= dither_next;
            same_reg     <= same_next;
            prev_dir_reg <= prev_dir_next;
            prev_ok_reg  <= prev_ok_next;
        end
    end

    assign code = code_reg;
    assign Sel  = state_reg;
    assign lock = lock_reg;
    assign eval = do_eval;
    assign sat  = track_reg && ((code_reg == '0) || (code_reg == '1));

endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// Testbench for fmdll_lock_ctrl.
// The reference model treats time as a position within the window sequence:
// a GATE prefix, then periods of 1+Mx cycles. It updates the code with plain
// integer arithmetic. A background process checks every output on each
// falling edge. Directed steps add literal checks at key points.
module tb_fmdll_lock_ctrl;

    localparam int CODE_W     = 10;
    localparam int N_W        = 4;
    localparam int M_W        = 2;
    localparam int LOCK_CNT   = 8;
    localparam int UNLOCK_ERR = 4;
    localparam int GATE_CYC   = 2;
    localparam int CODE_MAX   = (1 << CODE_W) - 1;
    localparam int MID        = 1 << (CODE_W - 1);

    logic              clk_ext  = 1'b0;
    logic              rst_n    = 1'b0;
    logic [N_W-1:0]    N        = 4'd4;
    logic [M_W-1:0]    M        = 2'd1;
    logic              pd_lead  = 1'b0;
    logic              pd_valid = 1'b0;
    logic [CODE_W-1:0] code;
    logic [1:0]        Sel;
    logic              lock;
    logic              eval;
    logic              sat;

    fmdll_lock_ctrl #(
        .CODE_W(CODE_W), .N_W(N_W), .M_W(M_W),
        .LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .GATE_CYC(GATE_CYC)
    ) dut (
        .clk_ext(clk_ext), .rst_n(rst_n), .N(N), .M(M),
        .pd_lead(pd_lead), .pd_valid(pd_valid),
        .code(code), .Sel(Sel), .lock(lock), .eval(eval), .sat(sat)
    );

    always #5 clk_ext = ~clk_ext;

    int total = 0;
    int bad   = 0;

    // Model state.
    bit m_ok = 0;
    int m_pos, m_bit, m_code, m_dith, m_same, m_n, m_m;
    bit m_sar, m_lock, m_prev, m_prev_ok;
    bit m_last = 0;
    bit m_ev;

    int seq_m1[4] = '{2, 1, 0, 1};
    int seq_m3[7] = '{2, 2, 1, 0, 0, 0, 1};
    int pat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int mx();
        return (m_m == 0) ? 1 : m_m;
    endfunction

    function automatic int exp_sel();
        int p;
        p = m_pos - GATE_CYC;
        if (p < 0) return 2;
        return ((p % (1 + mx())) == 0) ? 1 : 0;
    endfunction

    function automatic bit at_last();
        int p;
        p = m_pos - GATE_CYC;
        return (p >= 0) && ((p % (1 + mx())) == mx());
    endfunction

    task automatic model_restart();
        m_pos = 0; m_sar = 1; m_bit = CODE_W - 1; m_code = MID; m_lock = 0;
        m_dith = 0; m_same = 0; m_prev = 0; m_prev_ok = 0;
        m_n = int'(N); m_m = int'(M);
    endtask

    task automatic model_apply(input bit lead);
        if (m_sar) begin
            if (!lead) m_code = m_code - (1 << m_bit);
            if (m_bit > 0) begin
                m_code = m_code + (1 << (m_bit - 1));
                m_bit  = m_bit - 1;
            end else begin
                m_sar = 0; m_prev_ok = 0; m_dith = 0; m_same = 0;
            end
        end else begin
            if (lead) m_code = (m_code < CODE_MAX) ? m_code + 1 : m_code;
            else      m_code = (m_code > 0) ? m_code - 1 : 0;
            if (!m_prev_ok) begin
                m_dith = 1; m_same = 0;
            end else if (lead != m_prev) begin
                m_dith = (m_dith + 1 > LOCK_CNT) ? LOCK_CNT : m_dith + 1;
                m_same = 0;
            end else begin
                m_dith = 0;
                m_same = (m_same + 1 > UNLOCK_ERR) ? UNLOCK_ERR : m_same + 1;
            end
            m_prev = lead; m_prev_ok = 1;
            if (m_lock && m_same >= UNLOCK_ERR) begin
                m_lock = 0; m_dith = 0;
            end else if (m_dith >= LOCK_CNT) begin
                m_lock = 1;
            end
        end
    endtask

    // Advance the model at each rising edge; compare at the falling edge.
    task automatic monitor();
        forever begin
            @(posedge clk_ext);
            if (!rst_n) begin
                model_restart();
                m_ok = 1;
            end else if (m_ok) begin
                if ((int'(N) != m_n) || (int'(M) != m_m)) begin
                    model_restart();
                end else begin
                    if (at_last() && pd_valid) model_apply(pd_lead);
                    m_pos++;
                end
            end
            @(negedge clk_ext);
            if (m_ok) begin
                m_last = at_last();
                m_ev   = rst_n && (int'(N) == m_n) && (int'(M) == m_m) && m_last && pd_valid;
                check("sel",  Sel,  exp_sel());
                check("code", code, m_code);
                check("lock", lock, m_lock);
                check("eval", eval, m_ev);
                check("sat",  sat,  (!m_sar && (m_code == 0 || m_code == CODE_MAX)));
            end
        end
    endtask

    // Hold pd_lead/pd_valid until the last RUN cycle of a window is consumed.
    task automatic window(input bit lead, input bit valid);
        int n;
        n = 0;
        pd_lead  = lead;
        pd_valid = valid;
        do begin
            @(negedge clk_ext); #1;
            n++;
        end while (!m_last && n < 40);
        check("window_timeout", m_last, 1);
        @(posedge clk_ext); #1;
        pd_valid = 1'b0;
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset, then the first window sequence with M=1.
        repeat (3) @(posedge clk_ext);
        #1;
        check("rst_code", code, 512);
        check("rst_sel",  Sel,  2);
        check("rst_lock", lock, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_ext); #1;
            check("seq_m1_sel", Sel, seq_m1[i]);
        end

        // SAR toward 0x2A5.
        pat = 'h2A5;
        for (int i = CODE_W - 1; i >= 0; i--) window(pat[i], 1'b1);
        check("sar_code", code, 677);
        check("sar_lock", lock, 0);

        // Alternating directions reach lock. Four downward steps then drop it.
        for (int i = 0; i < 8; i++) window((i % 2) == 0, 1'b1);
        check("lock_code", code, 677);
        check("lock_up",   lock, 1);
        for (int i = 0; i < 4; i++) window(1'b0, 1'b1);
        check("unlock_code", code, 673);
        check("unlock_lock", lock, 0);

        // Restart through reset. All-lead SAR saturates at the top of the
        // code range. After that, add invalid windows.
        rst_n = 1'b0;
        @(posedge clk_ext); #1;
        rst_n = 1'b1;
        for (int i = 0; i < CODE_W; i++) window(1'b1, 1'b1);
        check("sar_ones", code, 1023);
        for (int i = 0; i < 2; i++) window(1'b1, 1'b1);
        check("sat_code", code, 1023);
        check("sat_flag", sat, 1);
        for (int i = 0; i < 2; i++) window(1'b0, 1'b0);
        check("novalid_code", code, 1023);

        // Lock again, then change N.
        for (int i = 0; i < 8; i++) window((i % 2) == 1, 1'b1);
        check("relock", lock, 1);
        N = 4'd6;
        @(posedge clk_ext); #1;
        check("nchg_sel",  Sel,  2);
        check("nchg_code", code, 512);
        check("nchg_lock", lock, 0);

        // M change to 3: RUN lasts three cycles.
        M = 2'd3;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk_ext); #1;
            check("seq_m3_sel", Sel, seq_m3[i]);
        end

        // A change on the last RUN cycle wins over the evaluation.
        pd_lead  = 1'b1;
        pd_valid = 1'b1;
        for (int n = 0; n < 40 && !m_last; n++) begin
            @(negedge clk_ext); #1;
        end
        N = 4'd9;
        #1;
        check("chg_beats_eval", eval, 0);
        @(posedge clk_ext); #1;
        pd_valid = 1'b0;
        check("chg2_sel",  Sel,  2);
        check("chg2_code", code, 512);

        // Apply reset in the middle of a SAR search.
        pat = 'h155;
        for (int i = CODE_W - 1; i >= CODE_W - 5; i--) window(pat[i], 1'b1);
        rst_n = 1'b0;
        @(posedge clk_ext); #1;
        check("midrst_code", code, 512);
        check("midrst_sel",  Sel,  2);
        check("midrst_lock", lock, 0);
        rst_n = 1'b1;
        for (int i = 1; i < 7; i++) begin
            @(posedge clk_ext); #1;
            check("midrst_seq", Sel, seq_m3[i]);
        end
        for (int i = CODE_W - 1; i >= 0; i--) window(pat[i], 1'b1);
        check("sar2_code", code, 341);

        repeat (4) @(posedge clk_ext);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
